ls_mem_responder: RTL

Data-memory responder for the pipeline's load/store port: a single-outstanding, valid/ready request/response slave backed by an internal doubleword SRAM with a configurable access latency. It is the memory-side counterpart of the LS stage. It accepts one read or byte-strobed write, waits `LATENCY` cycles, then presents the response. The response is held until the core takes it.

---
 rtl/ls_mem_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ls_mem_responder.sv
// ls_mem_responder
//
// Memory-side counterpart of the load/store stage. It accepts one read or
// byte-strobed write at a time, waits LATENCY cycles, performs the access
// on an internal doubleword array, then holds the response until the core
// takes it.
//
// Handshake rules: a transfer happens on a rising edge where both valid and
// ready are high. The request side is ready only in IDLE. The response side
// is valid only in RESP, and rsp_rdata/rsp_err stay constant until the
// transfer edge.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    request handshake
//   req_addr           byte address (bits [2:0] ignored)
//   req_wen            1 = write, 0 = read
//   req_wdata          write data
//   req_wstrb          byte enables for writes
//   rsp_valid/ready    response handshake
//   rsp_rdata          read data (0 for writes and errors)
//   rsp_err            address fell outside the array
//   dbg_state          current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module ls_mem_responder #(
    parameter int              XLEN      = 64,
    parameter int              ADDR_W    = 10,
    parameter int              LATENCY   = 2,
    parameter logic [XLEN-1:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic              req_wen,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN/8-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);

    localparam int         NBYTES   = XLEN / 8;
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       accept;
    logic       access;

    logic [XLEN-1:0]   addr_q;
    logic              wen_q;
    logic [XLEN-1:0]   wdata_q;
    logic [NBYTES-1:0] wstrb_q;

    logic [XLEN-1:0]   offset;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic              unused_offset_lo;

    // Array contents are deliberately not reset; they behave like SRAM.
    logic [XLEN-1:0] mem [DEPTH];

    // Unsigned subtraction wraps for addresses below BASE_ADDR, so the
    // explicit >= compare is what rejects them.
    assign offset           = addr_q - BASE_ADDR;
    assign in_range         = (addr_q >= BASE_ADDR) && (offset[XLEN-1:ADDR_W+3] == '0);
    assign idx              = offset[ADDR_W+2:3];
    assign unused_offset_lo = ^offset[2:0];

    assign dbg_state = state;

    // State register and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        accept    = 1'b0;
        access    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_n   = CNT_INIT;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    access  = 1'b1;
                    state_n = ST_RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Request fields are captured only on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wen_q   <= req_wen;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    // Array write. The access strobe only exists in WAIT, so a reset before
    // the access edge drops the pending write.
    always_ff @(posedge clk) begin
        if (access && wen_q && in_range) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wstrb_q[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    // Response registers only change on the access edge, which keeps them
    // stable for as long as RESP is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (access) begin
            rsp_err   <= !in_range;
            rsp_rdata <= (in_range && !wen_q) ? mem[idx] : '0;
        end
    end

endmodule
